// File: rtl/prf_wb_arbiter.sv
// prf_wb_arbiter: round-robin arbiter sharing the PRF write ports among the writeback units
// Ports: clk, rst (async, active-high), stall, flush; req_valid/req_rd/req_data in and
// req_ready out per requester (0=ALU, 1=LS, 2=BRANCH); wb_en/wb_rd/wb_data registered per
// PRF write port; conflict_cnt counts active cycles with more valid requests than ports.
module prf_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int WB_PORTS   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int PHY_WIDTH  = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*PHY_WIDTH-1:0]   req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [WB_PORTS-1:0]            wb_en,
  output logic [WB_PORTS*PHY_WIDTH-1:0]  wb_rd,
  output logic [WB_PORTS*DATA_WIDTH-1:0] wb_data,
  output logic [CNT_WIDTH-1:0]           conflict_cnt
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0] rr_ptr, last, next_ptr;
  logic [PW-1:0] port_idx [WB_PORTS];
  logic [WB_PORTS-1:0] port_en;
  logic active, tag_clash;
  assign active = !rst && !stall && !flush;
  // Scan from rr_ptr; the n-th valid requester found lands on port n.
  always_comb begin
    int cnt;
    int idx;
    cnt = 0;
    idx = 0;
    req_ready = '0;
    port_en = '0;
    last = rr_ptr;
    for (int p = 0; p < WB_PORTS; p++) port_idx[p] = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (active && req_valid[idx] && cnt < WB_PORTS) begin
        req_ready[idx] = 1'b1;
        port_en[cnt] = 1'b1;
        port_idx[cnt] = PW'(idx);
        last = PW'(idx);
        cnt++;
      end
    end
  end
  assign next_ptr = (int'(last) == NUM_REQ - 1) ? '0 : last + 1'b1;
  // Two ports granted the same tag in one cycle; the PRF lets the lower port win.
  always_comb begin
    tag_clash = 1'b0;
    for (int i = 0; i < WB_PORTS; i++)
      for (int j = i + 1; j < WB_PORTS; j++)
        if (port_en[i] && port_en[j] &&
            req_rd[int'(port_idx[i])*PHY_WIDTH +: PHY_WIDTH] == req_rd[int'(port_idx[j])*PHY_WIDTH +: PHY_WIDTH])
          tag_clash = 1'b1;
  end
  always_ff @(posedge clk) assert (!tag_clash);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en <= '0;
      wb_rd <= '0;
      wb_data <= '0;
      conflict_cnt <= '0;
      rr_ptr <= '0;
    end else begin
      if (flush) wb_en <= '0;
      else if (!stall) begin
        wb_en <= port_en;
        for (int p = 0; p < WB_PORTS; p++)
          if (port_en[p]) begin
            wb_rd[p*PHY_WIDTH +: PHY_WIDTH] <= req_rd[int'(port_idx[p])*PHY_WIDTH +: PHY_WIDTH];
            wb_data[p*DATA_WIDTH +: DATA_WIDTH] <= req_data[int'(port_idx[p])*DATA_WIDTH +: DATA_WIDTH];
          end
        if (|port_en) rr_ptr <= next_ptr;
      end
      if (!stall && !flush && $countones(req_valid) > WB_PORTS && !(&conflict_cnt))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
endmodule
